// File: rtl/inst_fetch_buffer.sv
// Fetch stage: issues one-outstanding imem requests from pc/ce and queues {pc, inst}
// pairs in a small FIFO that decode drains with valid/ready.
module inst_fetch_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic                       ce_i,
  input  logic                       flush_i,
  output logic                       fetch_stall_o,
  output logic                       imem_req_o,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic                       imem_gnt_i,
  input  logic                       imem_rvalid_i,
  input  logic [DATA_W-1:0]          imem_rdata_i,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [DATA_W-1:0]          id_inst_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int USE_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0]   pc_mem_q   [DEPTH];
  logic [DATA_W-1:0]   inst_mem_q [DEPTH];

  logic                pop, push, accept, can_issue, has_room;
  logic [USE_W-1:0]    used, limit;

  // Handshakes: imem request transfers when imem_req_o & imem_gnt_i in the same cycle
  // (req may drop before gnt); the FIFO head transfers when id_valid_o & id_ready_i.
  always_comb begin
    id_valid_o = (count_q != '0);
    pop        = id_valid_o & id_ready_i;
    push       = (state_q == S_WAIT) & imem_rvalid_i & ~flush_i;
    // The in-flight response already owns a slot, so it is counted as used.
    used       = USE_W'(count_q) + USE_W'(state_q == S_WAIT);
    limit      = USE_W'(DEPTH) + USE_W'(pop);
    has_room   = (used < limit);
    can_issue  = (state_q == S_IDLE) | ((state_q == S_WAIT) & imem_rvalid_i);
    imem_req_o = ce_i & ~flush_i & ~rst & can_issue & has_room;
    accept     = imem_req_o & imem_gnt_i;
    fetch_stall_o = ce_i & ~rst & ~accept;
    imem_addr_o   = pc_i;
    id_pc_o       = id_valid_o ? pc_mem_q[rd_ptr_q]   : '0;
    id_inst_o     = id_valid_o ? inst_mem_q[rd_ptr_q] : '0;
    count_o       = count_q;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pend_pc_d = pend_pc_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      // A response still owed after the flush must be swallowed in DROP.
      case (state_q)
        S_WAIT:  state_d = imem_rvalid_i ? S_IDLE : S_DROP;
        S_DROP:  state_d = imem_rvalid_i ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (accept) pend_pc_d = pc_i;
      case (state_q)
        S_IDLE:  if (accept) state_d = S_WAIT;
        S_WAIT:  if (imem_rvalid_i) state_d = accept ? S_WAIT : S_IDLE;
        S_DROP:  if (imem_rvalid_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Storage needs no reset: reads are masked while count is zero.
  always_ff @(posedge clk) begin
    if (push & ~rst) begin
      pc_mem_q[wr_ptr_q]   <= pend_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: a per-cycle vector table plus hand-written
// sequences for FIFO-full, grant delay, flush/drop and mid-transaction reset.
module tb_inst_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst, ce_i, flush_i, imem_gnt_i, imem_rvalid_i, id_ready_i;
  logic [31:0] pc_i, imem_rdata_i;
  logic        fetch_stall_o, imem_req_o, id_valid_o;
  logic [31:0] imem_addr_o, id_pc_o, id_inst_o;
  logic [2:0]  count_o;

  int n_pass  = 0;
  int n_total = 0;

  inst_fetch_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .flush_i(flush_i),
    .fetch_stall_o(fetch_stall_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, ce, fl, gnt, rv, rdy;
    logic [31:0] pc, rdata;
    logic        e_req, e_stall, e_val;
    logic [31:0] e_pc, e_inst;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic r, ce, fl, gnt, rv, rdy,
                              input logic [31:0] pc, rdata,
                              input logic e_req, e_stall, e_val,
                              input logic [31:0] e_pc, e_inst, input logic [2:0] e_cnt);
    vec_t v;
    v.r = r; v.ce = ce; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rdy = rdy;
    v.pc = pc; v.rdata = rdata;
    v.e_req = e_req; v.e_stall = e_stall; v.e_val = e_val;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance past the posedge.
  task automatic cyc(input string tag, input logic r, ce, fl, gnt, rv, rdy,
                     input logic [31:0] pc, rdata,
                     input logic e_req, e_stall, e_val,
                     input logic [31:0] e_pc, e_inst, input logic [2:0] e_cnt);
    rst = r; ce_i = ce; flush_i = fl; imem_gnt_i = gnt; imem_rvalid_i = rv;
    id_ready_i = rdy; pc_i = pc; imem_rdata_i = rdata;
    #4;
    chk({tag, ".req"},   32'(imem_req_o),    32'(e_req));
    chk({tag, ".stall"}, 32'(fetch_stall_o), 32'(e_stall));
    chk({tag, ".valid"}, 32'(id_valid_o),    32'(e_val));
    chk({tag, ".id_pc"}, id_pc_o,            e_pc);
    chk({tag, ".inst"},  id_inst_o,          e_inst);
    chk({tag, ".count"}, 32'(count_o),       32'(e_cnt));
    chk({tag, ".addr"},  imem_addr_o,        pc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ce_i = 0; flush_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0;
    id_ready_i = 0; pc_i = 0; imem_rdata_i = 0;
    @(posedge clk);
    #1;
    cyc("reset", 1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0);

    // Streaming 0,4,8 then a wrap-around run with simultaneous push/pop at count 2.
    vecs[0]  = mk(0,1,0,1,0,1, 32'h0,   32'h0,  1,0,0, 32'h0,   32'h0,  0);
    vecs[1]  = mk(0,1,0,1,1,1, 32'h4,   32'h11, 1,0,0, 32'h0,   32'h0,  0);
    vecs[2]  = mk(0,1,0,1,1,1, 32'h8,   32'h22, 1,0,1, 32'h0,   32'h11, 1);
    vecs[3]  = mk(0,0,0,0,1,1, 32'h8,   32'h33, 0,0,1, 32'h4,   32'h22, 1);
    vecs[4]  = mk(0,0,0,0,0,1, 32'h0,   32'h0,  0,0,1, 32'h8,   32'h33, 1);
    vecs[5]  = mk(0,0,0,0,0,1, 32'h0,   32'h0,  0,0,0, 32'h0,   32'h0,  0);
    vecs[6]  = mk(0,1,0,1,0,0, 32'h100, 32'h0,  1,0,0, 32'h0,   32'h0,  0);
    vecs[7]  = mk(0,1,0,1,1,0, 32'h104, 32'hA0, 1,0,0, 32'h0,   32'h0,  0);
    vecs[8]  = mk(0,1,0,1,1,0, 32'h108, 32'hA1, 1,0,1, 32'h100, 32'hA0, 1);
    vecs[9]  = mk(0,1,0,1,1,1, 32'h10C, 32'hA2, 1,0,1, 32'h100, 32'hA0, 2);
    vecs[10] = mk(0,0,0,0,1,1, 32'h10C, 32'hA3, 0,0,1, 32'h104, 32'hA1, 2);
    vecs[11] = mk(0,0,0,0,0,1, 32'h0,   32'h0,  0,0,1, 32'h108, 32'hA2, 2);
    vecs[12] = mk(0,0,0,0,0,1, 32'h0,   32'h0,  0,0,1, 32'h10C, 32'hA3, 1);
    vecs[13] = mk(0,0,0,0,0,1, 32'h0,   32'h0,  0,0,0, 32'h0,   32'h0,  0);
    for (int i = 0; i < 14; i++)
      cyc($sformatf("vec%0d", i), vecs[i].r, vecs[i].ce, vecs[i].fl, vecs[i].gnt,
          vecs[i].rv, vecs[i].rdy, vecs[i].pc, vecs[i].rdata, vecs[i].e_req,
          vecs[i].e_stall, vecs[i].e_val, vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_cnt);

    // FIFO fills with decode stalled; one pop lets exactly one request through.
    cyc("full0", 0,1,0,1,0,0, 32'h200, 32'h0,  1,0,0, 32'h0,   32'h0,  0);
    cyc("full1", 0,1,0,1,1,0, 32'h204, 32'hB0, 1,0,0, 32'h0,   32'h0,  0);
    cyc("full2", 0,1,0,1,1,0, 32'h208, 32'hB1, 1,0,1, 32'h200, 32'hB0, 1);
    cyc("full3", 0,1,0,1,1,0, 32'h20C, 32'hB2, 1,0,1, 32'h200, 32'hB0, 2);
    cyc("full4", 0,1,0,1,1,0, 32'h210, 32'hB3, 0,1,1, 32'h200, 32'hB0, 3);
    cyc("full5", 0,1,0,1,0,0, 32'h210, 32'h0,  0,1,1, 32'h200, 32'hB0, 4);
    cyc("full6", 0,1,0,1,0,1, 32'h210, 32'h0,  1,0,1, 32'h200, 32'hB0, 4);
    cyc("full7", 0,1,0,1,0,0, 32'h214, 32'h0,  0,1,1, 32'h204, 32'hB1, 3);
    cyc("full8", 0,1,0,1,1,0, 32'h214, 32'hB4, 0,1,1, 32'h204, 32'hB1, 3);
    cyc("full9", 0,1,0,1,0,0, 32'h214, 32'h0,  0,1,1, 32'h204, 32'hB1, 4);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("drain%0d", i), 0,0,0,0,0,1, 32'h0, 32'h0, 0,0,1,
          32'h204 + 32'(4*i), 32'hB1 + 32'(i), 3'(4-i));
    cyc("drained", 0,0,0,0,0,1, 32'h0, 32'h0, 0,0,0, 32'h0, 32'h0, 0);

    // Grant withheld for three cycles: pc held and stall raised.
    for (int i = 0; i < 3; i++)
      cyc($sformatf("nogrant%0d", i), 0,1,0,0,0,1, 32'h10, 32'h0, 1,1,0, 32'h0, 32'h0, 0);
    cyc("grant",   0,1,0,1,0,1, 32'h10, 32'h0,    1,0,0, 32'h0,  32'h0,    0);
    cyc("rvalid",  0,0,0,0,1,1, 32'h10, 32'hC0DE, 0,0,0, 32'h0,  32'h0,    0);
    cyc("popped",  0,0,0,0,0,1, 32'h10, 32'h0,    0,0,1, 32'h10, 32'hC0DE, 1);
    cyc("empty3",  0,0,0,0,0,1, 32'h10, 32'h0,    0,0,0, 32'h0,  32'h0,    0);

    // Flush while waiting: the late response is dropped, then fetch resumes.
    cyc("fl0", 0,1,0,1,0,0, 32'h20, 32'h0,    1,0,0, 32'h0,  32'h0,  0);
    cyc("fl1", 0,1,0,1,1,0, 32'h24, 32'h99,   1,0,0, 32'h0,  32'h0,  0);
    cyc("fl2", 0,1,1,1,0,0, 32'h40, 32'h0,    0,1,1, 32'h20, 32'h99, 1);
    cyc("fl3", 0,1,0,1,0,0, 32'h40, 32'h0,    0,1,0, 32'h0,  32'h0,  0);
    cyc("fl4", 0,1,0,1,1,0, 32'h40, 32'hDEAD, 0,1,0, 32'h0,  32'h0,  0);
    cyc("fl5", 0,1,0,1,0,0, 32'h40, 32'h0,    1,0,0, 32'h0,  32'h0,  0);
    cyc("fl6", 0,0,0,0,1,0, 32'h40, 32'h44,   0,0,0, 32'h0,  32'h0,  0);
    cyc("fl7", 0,0,0,0,0,1, 32'h40, 32'h0,    0,0,1, 32'h40, 32'h44, 1);
    cyc("fl8", 0,0,0,0,0,1, 32'h40, 32'h0,    0,0,0, 32'h0,  32'h0,  0);

    // Reset mid-transaction with one entry queued; stale response afterwards ignored.
    cyc("rs0", 0,1,0,1,0,0, 32'h50, 32'h0,   1,0,0, 32'h0,  32'h0,  0);
    cyc("rs1", 0,1,0,1,1,0, 32'h54, 32'h55,  1,0,0, 32'h0,  32'h0,  0);
    cyc("rs2", 1,0,0,0,0,0, 32'h54, 32'h0,   0,0,1, 32'h50, 32'h55, 1);
    cyc("rs3", 0,0,0,0,1,0, 32'h54, 32'hBAD, 0,0,0, 32'h0,  32'h0,  0);
    cyc("rs4", 0,0,0,0,0,1, 32'h0,  32'h0,   0,0,0, 32'h0,  32'h0,  0);
    cyc("rs5", 0,1,0,1,0,0, 32'h60, 32'h0,   1,0,0, 32'h0,  32'h0,  0);
    cyc("rs6", 0,0,0,0,1,0, 32'h60, 32'h66,  0,0,0, 32'h0,  32'h0,  0);
    cyc("rs7", 0,0,0,0,0,1, 32'h60, 32'h0,   0,0,1, 32'h60, 32'h66, 1);
    cyc("rs8", 0,0,0,0,0,1, 32'h60, 32'h0,   0,0,0, 32'h0,  32'h0,  0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
